// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests,
// fills the IF/ID latch and decodes rs1/rs2/rd identifiers for the hazard unit.
module fetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            data_hazard,
    input  logic            control_hazard,
    input  logic            jump_taken,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_req,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            if_valid,
    output logic [4:0]      a0,
    output logic [4:0]      a1,
    output logic [4:0]      a2,
    output logic            misalign
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        SHADOW = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       if_instr_q, if_instr_d;
    logic [XLEN-1:0]   if_pc_q, if_pc_d;
    logic              if_valid_q, if_valid_d;
    logic              misalign_q, misalign_d;
    logic              active;
    logic [OPC_W-1:0]  opcode;

    assign active = (state_q == RUN) || (state_q == SHADOW);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a redirect enters SHADOW; everything else settles in RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN, SHADOW: begin
                if (stall) begin
                    state_d = state_q;
                end else if (jump_taken) begin
                    state_d = SHADOW;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // FSM outputs: memory is only requested once out of BOOT
    always_comb begin
        imem_req = 1'b0;
        if (active) begin
            imem_req = 1'b1;
        end
    end

    // PC / IF-ID next-state selection, highest-priority condition first
    always_comb begin
        pc_d       = pc_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        misalign_d = misalign_q;
        if (active) begin
            if (stall) begin
                pc_d = pc_q;
            end else if (jump_taken) begin
                pc_d       = {jump_target[XLEN-1:2], 2'b00};
                misalign_d = misalign_q | (jump_target[1:0] != 2'b00);
                if_instr_d = NOP;
                if_valid_d = 1'b0;
            end else if (control_hazard) begin
                if_instr_d = NOP;
                if_valid_d = 1'b0;
            end else if (data_hazard) begin
                pc_d = pc_q;
            end else if (!imem_ready) begin
                if_instr_d = NOP;
                if_valid_d = 1'b0;
            end else begin
                if_instr_d = imem_rdata;
                if_pc_d    = pc_q;
                if_valid_d = 1'b1;
                pc_d       = pc_q + XLEN'(4);
            end
        end
    end

    // PC, IF/ID latch and sticky misalign flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            if_instr_q <= NOP;
            if_pc_q    <= RESET_PC;
            if_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
            misalign_q <= misalign_d;
        end
    end

    // Register identifiers for the hazard unit; bubbles report no registers
    always_comb begin
        opcode = if_instr_q[OPC_W-1:0];
        a0     = '0;
        a1     = '0;
        a2     = '0;
        if (if_valid_q) begin
            case (opcode)
                OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP:
                    a0 = if_instr_q[19:15];
                default: a0 = REG_W'(0);
            endcase
            case (opcode)
                OPC_BRANCH, OPC_STORE, OPC_OP:
                    a1 = if_instr_q[24:20];
                default: a1 = REG_W'(0);
            endcase
            case (opcode)
                OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OP:
                    a2 = if_instr_q[11:7];
                default: a2 = REG_W'(0);
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign if_valid  = if_valid_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a driver walks a directed vector table and
// queues the expected post-edge state; a monitor pops and compares.
module tb_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] I_ADDI = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_ADD  = 32'h0020_81B3; // add  x3,x1,x2
    localparam logic [31:0] I_SW   = 32'h0053_2423; // sw   x5,8(x6)
    localparam logic [31:0] I_BEQ  = 32'h0083_8063; // beq  x7,x8,0
    localparam logic [31:0] I_LUI  = 32'h1234_5537; // lui  x10,0x12345
    localparam logic [31:0] I_LW   = 32'h0006_2583; // lw   x11,0(x12)
    localparam logic [31:0] I_JAL  = 32'h0000_00EF; // jal  x1,0

    logic        clk;
    logic        rst;
    logic        stall;
    logic        data_hazard;
    logic        control_hazard;
    logic        jump_taken;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        misalign;

    fetch_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0),
        .NOP      (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .data_hazard    (data_hazard),
        .control_hazard (control_hazard),
        .jump_taken     (jump_taken),
        .jump_target    (jump_target),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_rdata     (imem_rdata),
        .imem_ready     (imem_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_valid       (if_valid),
        .a0             (a0),
        .a1             (a1),
        .a2             (a2),
        .misalign       (misalign)
    );

    typedef struct {
        int          idx;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] epc;
        logic [31:0] ea;
        logic [4:0]  e0;
        logic [4:0]  e1;
        logic [4:0]  e2;
        logic        ereq;
        logic        emis;
    } exp_t;

    typedef struct {
        bit          ar;
        logic        st;
        logic        dh;
        logic        ch;
        logic        jt;
        logic [31:0] jtgt;
        logic        rdy;
        logic [31:0] rdata;
        exp_t        e;
    } row_t;

    row_t rows[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic row_t mk(input bit ar, input logic st, input logic dh,
                                input logic ch, input logic jt, input logic [31:0] jtgt,
                                input logic rdy, input logic [31:0] rdata,
                                input logic ev, input logic [31:0] ei, input logic [31:0] epc,
                                input logic [31:0] ea, input logic [4:0] e0,
                                input logic [4:0] e1, input logic [4:0] e2,
                                input logic ereq, input logic emis);
        row_t r;
        r.ar = ar; r.st = st; r.dh = dh; r.ch = ch; r.jt = jt; r.jtgt = jtgt;
        r.rdy = rdy; r.rdata = rdata;
        r.e.idx = 0; r.e.ev = ev; r.e.ei = ei; r.e.epc = epc; r.e.ea = ea;
        r.e.e0 = e0; r.e.e1 = e1; r.e.e2 = e2; r.e.ereq = ereq; r.e.emis = emis;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL row %0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    // Monitor: every clock edge or asynchronous reset presents a new DUT state
    always @(posedge clk or posedge rst) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("imem_addr", e.idx, imem_addr, e.ea);
            chk("imem_req", e.idx, 32'(imem_req), 32'(e.ereq));
            chk("if_valid", e.idx, 32'(if_valid), 32'(e.ev));
            chk("if_instr", e.idx, if_instr, e.ei);
            chk("if_pc", e.idx, if_pc, e.epc);
            chk("a0", e.idx, 32'(a0), 32'(e.e0));
            chk("a1", e.idx, 32'(a1), 32'(e.e1));
            chk("a2", e.idx, 32'(a2), 32'(e.e2));
            chk("misalign", e.idx, 32'(misalign), 32'(e.emis));
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    // Driver
    initial begin
        rst = 1'b0; stall = 1'b0; data_hazard = 1'b0; control_hazard = 1'b0;
        jump_taken = 1'b0; jump_target = '0; imem_ready = 1'b0; imem_rdata = '0;

        //              ar st dh ch jt jtgt          rdy rdata   ev ei      if_pc         imem_addr     a0 a1 a2 req mis
        rows.push_back(mk(1, 0, 0, 0, 0, 32'h0,        1, I_ADDI, 0, NOP,    32'h0,        32'h0,        0, 0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, I_ADDI, 0, NOP,    32'h0,        32'h0,        0, 0, 0, 1, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, I_ADDI, 1, I_ADDI, 32'h0,        32'h4,        0, 0, 1, 1, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, I_ADD,  1, I_ADD,  32'h4,        32'h8,        1, 2, 3, 1, 0));
        rows.push_back(mk(0, 0, 1, 0, 0, 32'h0,        1, I_SW,   1, I_ADD,  32'h4,        32'h8,        1, 2, 3, 1, 0));
        rows.push_back(mk(0, 0, 1, 0, 0, 32'h0,        1, I_SW,   1, I_ADD,  32'h4,        32'h8,        1, 2, 3, 1, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, I_SW,   1, I_SW,   32'h8,        32'hC,        6, 5, 0, 1, 0));
        rows.push_back(mk(0, 0, 0, 1, 1, 32'h100,      1, I_BEQ,  0, NOP,    32'h8,        32'h100,      0, 0, 0, 1, 0));
        rows.push_back(mk(0, 0, 0, 1, 0, 32'h0,        1, I_LUI,  0, NOP,    32'h8,        32'h100,      0, 0, 0, 1, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, I_LUI,  1, I_LUI,  32'h100,      32'h104,      0, 0, 10, 1, 0));
        rows.push_back(mk(0, 1, 0, 0, 1, 32'h200,      1, I_LW,   1, I_LUI,  32'h100,      32'h104,      0, 0, 10, 1, 0));
        rows.push_back(mk(0, 0, 0, 0, 1, 32'h200,      1, I_LW,   0, NOP,    32'h100,      32'h200,      0, 0, 0, 1, 0));
        rows.push_back(mk(0, 0, 0, 1, 0, 32'h0,        1, I_LW,   0, NOP,    32'h100,      32'h200,      0, 0, 0, 1, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, I_LW,   1, I_LW,   32'h200,      32'h204,      12, 0, 11, 1, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0, I_JAL,  0, NOP,    32'h200,      32'h204,      0, 0, 0, 1, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0, I_JAL,  0, NOP,    32'h200,      32'h204,      0, 0, 0, 1, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 32'h0,        0, I_JAL,  0, NOP,    32'h200,      32'h204,      0, 0, 0, 1, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, I_JAL,  1, I_JAL,  32'h204,      32'h208,      0, 0, 1, 1, 0));
        rows.push_back(mk(0, 0, 0, 0, 1, 32'h102,      1, I_BEQ,  0, NOP,    32'h204,      32'h100,      0, 0, 0, 1, 1));
        rows.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, I_BEQ,  1, I_BEQ,  32'h100,      32'h104,      7, 8, 0, 1, 1));
        rows.push_back(mk(0, 0, 0, 0, 1, 32'hFFFFFFFC, 1, I_ADD,  0, NOP,    32'h100,      32'hFFFFFFFC, 0, 0, 0, 1, 1));
        rows.push_back(mk(0, 0, 0, 1, 0, 32'h0,        1, I_ADD,  0, NOP,    32'h100,      32'hFFFFFFFC, 0, 0, 0, 1, 1));
        rows.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, I_ADD,  1, I_ADD,  32'hFFFFFFFC, 32'h0,        1, 2, 3, 1, 1));
        rows.push_back(mk(0, 0, 0, 0, 1, 32'h300,      1, I_LW,   0, NOP,    32'hFFFFFFFC, 32'h300,      0, 0, 0, 1, 1));
        rows.push_back(mk(1, 0, 0, 1, 0, 32'h0,        1, I_ADDI, 0, NOP,    32'h0,        32'h0,        0, 0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, I_ADDI, 0, NOP,    32'h0,        32'h0,        0, 0, 0, 1, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, I_ADDI, 1, I_ADDI, 32'h0,        32'h4,        0, 0, 1, 1, 0));

        foreach (rows[i]) begin
            exp_t e;
            @(negedge clk);
            stall          = rows[i].st;
            data_hazard    = rows[i].dh;
            control_hazard = rows[i].ch;
            jump_taken     = rows[i].jt;
            jump_target    = rows[i].jtgt;
            imem_ready     = rows[i].rdy;
            imem_rdata     = rows[i].rdata;
            e = rows[i].e;
            e.idx = i;
            exp_q.push_back(e);
            if (rows[i].ar) begin
                #2 rst = 1'b1;
            end else begin
                rst = 1'b0;
            end
        end

        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries never compared, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage at the head of the pipeline. It owns the PC and drives the instruction-memory request.
- It registers the fetched instruction into the IF/ID latch and obeys the stall, data_hazard and control_hazard outputs of the hazards controller.
- Each cycle it supplies the controller's register identifiers a0/a1/a2 (rs1/rs2/rd) and its jump_taken redirect.
- The hazards controller is the direct consumer of this block's identifier outputs and the producer of its hold/squash inputs.

Parameters:
XLEN, 32, PC/address width
RESET_PC, 32'h00000000, PC value loaded on reset
NOP, 32'h00000013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
stall  in  1  full-pipeline stall from hazards controller
data_hazard  in  1  data hazard from hazards controller
control_hazard  in  1  control hazard from hazards controller
jump_taken  in  1  redirect request from execute
jump_target  in  XLEN  redirect address
imem_addr  out  XLEN  instruction-memory address (= pc)
imem_req  out  1  fetch request
imem_rdata  in  32  instruction word, valid when imem_ready=1
imem_ready  in  1  instruction memory returns data this cycle
if_instr  out  32  registered instruction to decode
if_pc  out  XLEN  PC of if_instr
if_valid  out  1  if_instr is a real instruction (0 = bubble)
a0  out  5  rs1 of if_instr, 0 if unused or bubble
a1  out  5  rs2 of if_instr, 0 if unused or bubble
a2  out  5  rd of if_instr, 0 if no write or bubble
misalign  out  1  sticky: a jump_target with bits[1:0]!=0 was accepted

Behaviour:
- Reset (async, any cycle, including mid-redirect):
  - pc=RESET_PC, if_instr=NOP, if_pc=RESET_PC, if_valid=0, misalign=0, state=BOOT.
  - imem_req=0 in BOOT. a0/a1/a2=0.
- FSM states: BOOT, RUN, SHADOW.
  - BOOT -> RUN after exactly one clock following reset release.
  - imem_req=1 in RUN and SHADOW.
  - imem_addr = pc combinationally, in every state.
- Per-edge priority in RUN/SHADOW, first match wins:
  1. stall=1: pc, IF/ID latch and state all hold.
  2. jump_taken=1:
     - pc <= {jump_target[XLEN-1:2],2'b00}.
     - misalign |= (jump_target[1:0]!=0).
     - IF/ID <= bubble (if_instr=NOP, if_valid=0, if_pc unchanged).
     - state <= SHADOW.
  3. control_hazard=1 (shadow cycle of the latched hazard): IF/ID <= bubble; pc holds; state <= RUN.
  4. data_hazard=1: pc and IF/ID hold (decode re-presents the same instruction).
  5. imem_ready=0: IF/ID <= bubble; pc holds.
  6. Otherwise: if_instr <= imem_rdata, if_pc <= pc, if_valid <= 1, pc <= pc+4.
- PC arithmetic:
  - Modulo 2^XLEN; pc+4 wraps from 32'hFFFFFFFC to 0.
  - pc[1:0] are always 0.
- Redirect penalty: the first target instruction enters IF/ID on the third edge after jump_taken; the two preceding edges insert bubbles.
- SHADOW with control_hazard unexpectedly low: treated as RUN (rules 4–6 apply), state <= RUN.
- Identifier decode (combinational from if_instr, opcode = bits[6:0]):
  - a0 = bits[19:15] for JALR, BRANCH, LOAD, STORE, OP-IMM, OP; else 0.
  - a1 = bits[24:20] for BRANCH, STORE, OP; else 0.
  - a2 = bits[11:7] for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP; else 0.
  - All identifiers are forced to 0 when if_valid=0.
- misalign is cleared only by rst.

Test Plan:
- Reset release, imem_ready=1, rdata=32'h00500093 -> BOOT one cycle with imem_req=0; next edge if_instr=32'h00500093, if_pc=0, if_valid=1, a2=1, a0=0, a1=0, pc=4.
- Sequential fetch with data_hazard=1 for 2 cycles at pc=8 -> pc stays 8, if_instr unchanged; after release pc=12.
- jump_taken=1, jump_target=32'h100, then control_hazard=1 for 2 cycles -> bubbles on two edges, imem_addr=32'h100 on both; third edge if_pc=32'h100, if_valid=1.
- stall=1 coincident with jump_taken=1 -> nothing changes; with stall dropped and jump_taken held, redirect occurs.
- imem_ready=0 for 3 cycles -> if_valid=0, a0/a1/a2=0, pc constant; resumes at same pc.
- jump_target=32'h102 -> pc=32'h100, misalign=1, stays 1 until rst; async rst asserted mid-SHADOW -> immediate pc=0, if_valid=0.
